// File: rtl/cam_ctrl.sv
// cam_ctrl: sequencing controller in front of a DEPTH-entry CAM.
// It accepts one lookup/insert/delete at a time, keeps the per-entry valid
// bitmap the CAM lacks, allocates free slots, evicts round-robin when full,
// and returns hit/index results over a response handshake.
//
// Ports:
//   clk_i, rst_i            clock, async active-low reset
//   req_valid_i/req_ready_o request handshake
//   req_op_i                00 lookup, 01 insert, 10 delete, 11 reserved
//   req_data_i/req_index_i  key (lookup/insert), entry (delete)
//   rsp_valid_o/rsp_ready_i response handshake
//   rsp_hit_o/rsp_index_o/rsp_evict_o  result fields
//   cam_write_o/_index_o/_data_o       CAM write port
//   cam_search_o/_data_o               CAM search port
//   cam_search_valid_i/_index_i        CAM result, the cycle after search
//   occupancy_o             number of valid entries
//
// state  | meaning
// IDLE   | ready for a request
// SEARCH | cam_search_o pulsed with the registered key
// EVAL   | CAM result sampled; lookup answered or insert slot chosen
// WRITE  | cam_write_o pulsed; valid bit set at the end of the cycle
// RESP   | response held until rsp_ready_i
module cam_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [1:0]            req_op_i,
  input  logic [DATA_WIDTH-1:0] req_data_i,
  input  logic [ADDR_WIDTH-1:0] req_index_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_hit_o,
  output logic [ADDR_WIDTH-1:0] rsp_index_o,
  output logic                  rsp_evict_o,
  output logic                  cam_write_o,
  output logic [ADDR_WIDTH-1:0] cam_write_index_o,
  output logic [DATA_WIDTH-1:0] cam_write_data_o,
  output logic                  cam_search_o,
  output logic [DATA_WIDTH-1:0] cam_search_data_o,
  input  logic                  cam_search_valid_i,
  input  logic [ADDR_WIDTH-1:0] cam_search_index_i,
  output logic [ADDR_WIDTH:0]   occupancy_o
);

  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_DELETE = 2'b10;
  localparam logic [ADDR_WIDTH:0] OCC_MAX = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEARCH,
    S_EVAL,
    S_WRITE,
    S_RESP
  } state_t;

  state_t                state_q;
  logic [DEPTH-1:0]      valid_q;
  logic [ADDR_WIDTH-1:0] evict_ptr_q;
  logic [1:0]            op_q;
  logic [DATA_WIDTH-1:0] key_q;
  logic                  req_ready_q;
  logic                  rsp_valid_q;
  logic                  rsp_hit_q;
  logic                  rsp_evict_q;
  logic [ADDR_WIDTH-1:0] rsp_index_q;
  logic                  cam_write_q;
  logic [ADDR_WIDTH-1:0] write_index_q;
  logic                  cam_search_q;
  logic [ADDR_WIDTH:0]   occ_q;

  logic                  hit_v;
  logic                  free_found;
  logic [ADDR_WIDTH-1:0] free_index;

  // A CAM match only counts if we consider that entry live.
  always_comb hit_v = cam_search_valid_i & valid_q[cam_search_index_i];

  // Lowest-index free entry; the descending scan leaves the lowest winner.
  always_comb begin
    free_found = 1'b0;
    free_index = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_index = ADDR_WIDTH'(i);
      end
    end
  end

  assign req_ready_o       = req_ready_q;
  assign rsp_valid_o       = rsp_valid_q;
  assign rsp_hit_o         = rsp_hit_q;
  assign rsp_index_o       = rsp_index_q;
  assign rsp_evict_o       = rsp_evict_q;
  assign cam_write_o       = cam_write_q;
  assign cam_write_index_o = write_index_q;
  assign cam_write_data_o  = key_q;
  assign cam_search_o      = cam_search_q;
  assign cam_search_data_o = key_q;
  assign occupancy_o       = occ_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= S_IDLE;
      valid_q       <= '0;
      evict_ptr_q   <= '0;
      op_q          <= '0;
      key_q         <= '0;
      req_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_hit_q     <= 1'b0;
      rsp_evict_q   <= 1'b0;
      rsp_index_q   <= '0;
      cam_write_q   <= 1'b0;
      write_index_q <= '0;
      cam_search_q  <= 1'b0;
      occ_q         <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid_i && req_ready_q) begin
            req_ready_q <= 1'b0;
            op_q        <= req_op_i;
            key_q       <= req_data_i;
            rsp_evict_q <= 1'b0;
            if (req_op_i == OP_LOOKUP || req_op_i == OP_INSERT) begin
              cam_search_q <= 1'b1;
              state_q      <= S_SEARCH;
            end else if (req_op_i == OP_DELETE) begin
              rsp_hit_q   <= valid_q[req_index_i];
              rsp_index_q <= req_index_i;
              if (valid_q[req_index_i]) begin
                valid_q[req_index_i] <= 1'b0;
                occ_q                <= occ_q - 1'b1;
              end
              rsp_valid_q <= 1'b1;
              state_q     <= S_RESP;
            end else begin
              rsp_hit_q   <= 1'b0;
              rsp_index_q <= '0;
              rsp_valid_q <= 1'b1;
              state_q     <= S_RESP;
            end
          end
        end

        S_SEARCH: begin
          cam_search_q <= 1'b0;
          state_q      <= S_EVAL;
        end

        S_EVAL: begin
          if (op_q == OP_LOOKUP || hit_v) begin
            rsp_hit_q   <= hit_v;
            rsp_index_q <= hit_v ? cam_search_index_i : '0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            rsp_hit_q <= 1'b0;
            if (cam_search_valid_i) begin
              // stale copy of this key: rewrite in place so no duplicate forms
              write_index_q <= cam_search_index_i;
            end else if (free_found) begin
              write_index_q <= free_index;
            end else begin
              write_index_q <= evict_ptr_q;
              rsp_evict_q   <= 1'b1;
              evict_ptr_q   <= evict_ptr_q + 1'b1;
            end
            cam_write_q <= 1'b1;
            state_q     <= S_WRITE;
          end
        end

        S_WRITE: begin
          cam_write_q <= 1'b0;
          if (!valid_q[write_index_q]) begin
            valid_q[write_index_q] <= 1'b1;
            if (occ_q != OCC_MAX) occ_q <= occ_q + 1'b1;
          end
          rsp_index_q <= write_index_q;
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end

        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_ctrl.sv
// Testbench for cam_ctrl: behavioural CAM responder, reference model of the
// valid bitmap / key table, scoreboard queues and decoupled monitors.
module tb_cam_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_op_i;
  logic [31:0] req_data_i;
  logic [4:0]  req_index_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic        rsp_hit_o;
  logic [4:0]  rsp_index_o;
  logic        rsp_evict_o;
  logic        cam_write_o;
  logic [4:0]  cam_write_index_o;
  logic [31:0] cam_write_data_o;
  logic        cam_search_o;
  logic [31:0] cam_search_data_o;
  logic        cam_search_valid_i = 1'b0;
  logic [4:0]  cam_search_index_i = '0;
  logic [5:0]  occupancy_o;

  cam_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_data_i(req_data_i), .req_index_i(req_index_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_hit_o(rsp_hit_o), .rsp_index_o(rsp_index_o), .rsp_evict_o(rsp_evict_o),
    .cam_write_o(cam_write_o), .cam_write_index_o(cam_write_index_o),
    .cam_write_data_o(cam_write_data_o),
    .cam_search_o(cam_search_o), .cam_search_data_o(cam_search_data_o),
    .cam_search_valid_i(cam_search_valid_i), .cam_search_index_i(cam_search_index_i),
    .occupancy_o(occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fire_cyc = 0;
  int search_cnt = 0;
  logic [31:0] cur_key = '0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural CAM (survives controller reset) ----------
  logic [31:0] cam_mem [32];

  always @(posedge clk_i) begin
    int m;
    m = -1;
    for (int i = 31; i >= 0; i--) if (cam_mem[i] == cam_search_data_o) m = i;
    cam_search_valid_i <= cam_search_o && (m >= 0);
    cam_search_index_i <= (cam_search_o && m >= 0) ? m[4:0] : 5'($urandom_range(0, 31));
    if (cam_write_o) cam_mem[cam_write_index_o] = cam_write_data_o;
  end

  // ---------------- reference model ---------------------------------------
  typedef struct {
    logic       hit;
    logic [4:0] idx;
    logic       evict;
    logic [5:0] occ;
    int         lat;
    int         nsearch;
  } exp_t;
  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
  } wr_t;

  exp_t exp_q[$];
  wr_t  wr_q[$];
  logic [31:0] ref_key [32];
  logic [31:0] save_key [32];
  logic [31:0] ref_valid;
  int          ref_ptr;

  task automatic model(input logic [1:0] op, input logic [31:0] key,
                       input logic [4:0] di, output exp_t e);
    int  m;
    int  slot;
    logic hit;
    wr_t w;
    e.hit = 0; e.idx = 0; e.evict = 0; e.lat = 1; e.nsearch = 0;
    if (op == 2'd0 || op == 2'd1) begin
      m = -1;
      for (int i = 31; i >= 0; i--) if (ref_key[i] == key) m = i;
      hit = (m >= 0) && ref_valid[m];
      e.nsearch = 1;
      e.lat = 3;
      if (hit) begin
        e.hit = 1; e.idx = 5'(m);
      end else if (op == 2'd1) begin
        slot = m;
        if (slot < 0)
          for (int i = 31; i >= 0; i--) if (!ref_valid[i]) slot = i;
        if (slot < 0) begin
          slot = ref_ptr;
          e.evict = 1;
          ref_ptr = (ref_ptr + 1) % 32;
        end
        ref_key[slot]   = key;
        ref_valid[slot] = 1'b1;
        e.idx = 5'(slot);
        e.lat = 4;
        w.idx = 5'(slot); w.data = key;
        wr_q.push_back(w);
      end
    end else if (op == 2'd2) begin
      e.hit = ref_valid[di];
      e.idx = di;
      ref_valid[di] = 1'b0;
    end
    e.occ = 6'($countones(ref_valid));
  endtask

  // ---------------- monitors ----------------------------------------------
  logic rsp_seen = 0;
  logic p_valid = 0, p_ready = 0, p_hit = 0, p_evict = 0;
  logic [4:0] p_idx = 0;

  always @(negedge clk_i) begin
    exp_t e;
    wr_t  w;
    if (rst_i === 1'b1) begin
      if (cam_search_o) begin
        search_cnt++;
        chk("search_key", cam_search_data_o, cur_key);
      end
      if (cam_write_o) begin
        if (wr_q.size() == 0) chk("write_unexpected", cam_write_o, 0);
        else begin
          w = wr_q.pop_front();
          chk("write_index", cam_write_index_o, w.idx);
          chk("write_data", cam_write_data_o, w.data);
        end
      end
      if (rsp_valid_o && !rsp_seen) begin
        rsp_seen = 1;
        if (exp_q.size() == 0) chk("rsp_unexpected", rsp_valid_o, 0);
        else begin
          e = exp_q.pop_front();
          chk("rsp_hit", rsp_hit_o, e.hit);
          chk("rsp_index", rsp_index_o, e.idx);
          chk("rsp_evict", rsp_evict_o, e.evict);
          chk("occupancy", occupancy_o, e.occ);
          chk("latency", cyc - fire_cyc + 1, e.lat);
          chk("search_count", search_cnt, e.nsearch);
          chk("write_missing", wr_q.size(), 0);
        end
        search_cnt = 0;
      end
      if (rsp_valid_o && p_valid && !p_ready) begin
        chk("hold_hit", rsp_hit_o, p_hit);
        chk("hold_index", rsp_index_o, p_idx);
        chk("hold_evict", rsp_evict_o, p_evict);
        chk("hold_req_ready", req_ready_o, 0);
      end
    end
    if (!rsp_valid_o) rsp_seen = 0;
    p_valid = rsp_valid_o; p_ready = rsp_ready_i;
    p_hit = rsp_hit_o; p_idx = rsp_index_o; p_evict = rsp_evict_o;
  end

  // ---------------- stimulus tasks ----------------------------------------
  task automatic apply_reset();
    rst_i = 0; req_valid_i = 0; rsp_ready_i = 0;
    #1;
    chk("rst_occupancy", occupancy_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_fields", {rsp_hit_o, rsp_index_o, rsp_evict_o}, 0);
    chk("rst_cam_write", cam_write_o, 0);
    chk("rst_cam_search", cam_search_o, 0);
    chk("rst_req_ready", req_ready_o, 0);
    ref_valid = '0; ref_ptr = 0;
    exp_q.delete(); wr_q.delete(); search_cnt = 0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1;
    @(posedge clk_i); #1;
    chk("ready_after_reset", req_ready_o, 1);
  endtask

  task automatic fire(input logic [1:0] op, input logic [31:0] key,
                      input logic [4:0] di, output logic ok);
    exp_t e;
    int   n;
    logic r;
    model(op, key, di, e);
    exp_q.push_back(e);
    cur_key = key;
    req_op_i = op; req_data_i = key; req_index_i = di; req_valid_i = 1;
    n = 0;
    do begin
      r = req_ready_o;
      @(posedge clk_i); #1;
      n++;
    end while (!r && n < 20);
    req_valid_i = 0;
    fire_cyc = cyc;
    chk("fire_timeout", r, 1);
    ok = r;
  endtask

  task automatic do_req(input logic [1:0] op, input logic [31:0] key,
                        input logic [4:0] di, input int hold);
    int   n;
    logic r;
    logic ok;
    fire(op, key, di, ok);
    if (!ok) return;
    n = 0;
    do begin
      rsp_ready_i = (n < hold) ? 1'b0 : ((n >= hold + 6) ? 1'b1 : 1'($urandom_range(0, 1)));
      r = rsp_valid_o && rsp_ready_i;
      @(posedge clk_i); #1;
      n++;
    end while (!r && n < hold + 40);
    rsp_ready_i = 0;
    chk("rsp_timeout", r, 1);
    if (r) chk("idle_after_rsp", req_ready_o, 1);
  endtask

  // ---------------- main sequence -----------------------------------------
  initial begin
    logic ok;
    int   n;
    int   r;
    for (int i = 0; i < 32; i++) begin
      cam_mem[i] = 32'hA500_0000 | 32'(i);
      ref_key[i] = 32'hA500_0000 | 32'(i);
    end
    req_op_i = 0; req_data_i = 0; req_index_i = 0;
    apply_reset();

    // insert, then lookup, then duplicate insert
    do_req(2'd1, 32'hDEADBEEF, 0, 0);
    chk("t1_occupancy", occupancy_o, 1);
    do_req(2'd0, 32'hDEADBEEF, 0, 0);
    do_req(2'd1, 32'hDEADBEEF, 0, 0);
    chk("t2_occupancy", occupancy_o, 1);
    // key equal to leftover CAM contents on an invalid entry
    do_req(2'd1, 32'hA500_0007, 0, 0);

    // fill, then evict 33 times to wrap the pointer
    apply_reset();
    for (int k = 0; k < 32; k++) do_req(2'd1, 32'(k), 0, 0);
    chk("t3_full", occupancy_o, 32);
    for (int j = 0; j <= 32; j++) do_req(2'd1, 32'h100 + 32'(j), 0, 0);
    chk("t3_still_full", occupancy_o, 32);

    // delete, stale lookup, reinsert in place, double delete
    do_req(2'd2, 0, 5'd5, 0);
    chk("t4_occupancy", occupancy_o, 31);
    do_req(2'd0, 32'h105, 0, 0);
    do_req(2'd1, 32'h105, 0, 0);
    do_req(2'd2, 0, 5'd9, 0);
    do_req(2'd2, 0, 5'd9, 0);
    chk("t4_double_delete", occupancy_o, 31);

    // held response, reserved op
    do_req(2'd0, 32'h110, 0, 10);
    do_req(2'd3, 32'h123, 5'd3, 0);

    // reset while the CAM write is in flight
    save_key = ref_key;
    fire(2'd1, 32'h7777, 0, ok);
    n = 0;
    while (!cam_write_o && n < 10) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk("t6_write_seen", cam_write_o, 1);
    rst_i = 0;
    #1;
    chk("t6_write_dropped", cam_write_o, 0);
    ref_key = save_key;
    apply_reset();
    repeat (6) @(posedge clk_i);
    #1 chk("t6_no_response", rsp_valid_o, 0);

    // randomized traffic
    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 9);
      if (r < 4)       do_req(2'd0, 32'($urandom_range(0, 63)) + (it[0] ? 32'h100 : 32'h0), 0, $urandom_range(0, 3));
      else if (r < 8)  do_req(2'd1, 32'($urandom_range(0, 63)) + (it[1] ? 32'h100 : 32'h0), 0, $urandom_range(0, 3));
      else if (r < 9)  do_req(2'd2, 0, 5'($urandom_range(0, 31)), $urandom_range(0, 3));
      else             do_req(2'd3, $urandom, 5'($urandom_range(0, 31)), 0);
    end

    repeat (5) @(posedge clk_i);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("writes_drained", wr_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/cam_ctrl.md
Name: cam_ctrl

Overview:
- Sequencing controller in front of the 32-entry CAM. It accepts one client request at a time (lookup, insert, delete) over a valid/ready handshake.
- It drives the CAM write and search ports and keeps the per-entry valid bitmap, which the CAM itself lacks.
- It allocates free slots, evicts round-robin when the CAM is full, and returns hit/index results over a second valid/ready handshake.

Parameters:
- DATA_WIDTH, 32, key width; matches CAM data width.
- ADDR_WIDTH, 5, CAM index width.
- DEPTH, 1<<ADDR_WIDTH, number of CAM entries.

Ports:
- clk_i  in  1  single clock
- rst_i  in  1  asynchronous, active-low reset
- req_valid_i  in  1  request present
- req_ready_o  out  1  controller can accept a request
- req_op_i  in  2  00 lookup, 01 insert, 10 delete, 11 reserved
- req_data_i  in  DATA_WIDTH  key for lookup/insert
- req_index_i  in  ADDR_WIDTH  entry to delete
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  client takes response
- rsp_hit_o  out  1  lookup: valid match; insert: key already present; delete: entry was valid
- rsp_index_o  out  ADDR_WIDTH  matched, allocated or deleted index
- rsp_evict_o  out  1  insert overwrote a valid entry
- cam_write_o  out  1  CAM write strobe
- cam_write_index_o  out  ADDR_WIDTH  CAM write index
- cam_write_data_o  out  DATA_WIDTH  CAM write data
- cam_search_o  out  1  CAM search strobe
- cam_search_data_o  out  DATA_WIDTH  CAM search key
- cam_search_valid_i  in  1  CAM match found; valid the cycle after cam_search_o
- cam_search_index_i  in  ADDR_WIDTH  lowest matching index (CAM priority encoder)
- occupancy_o  out  ADDR_WIDTH+1  count of valid entries

Behaviour:
- **Reset (rst_i=0, async):**
  - FSM goes to IDLE; valid bitmap is cleared; eviction pointer is 0; occupancy_o is 0.
  - All outputs are 0 except req_ready_o, which is 1 once reset is released.
  - Reset during any state aborts the operation: no response is produced and no pending CAM write is issued.
- **Handshake:**
  - A request fires when req_valid_i & req_ready_o. req_ready_o=1 only in IDLE, so one operation is outstanding at a time.
  - The key, op and index are registered on the firing edge.
  - rsp_valid_o and all rsp_* fields hold stable until rsp_ready_i=1. The FSM returns to IDLE on that edge.
- **FSM states:** IDLE, SEARCH, EVAL, WRITE, RESP.
  - IDLE -> SEARCH (lookup/insert), or IDLE -> RESP (delete, reserved).
  - SEARCH: cam_search_o=1 for exactly one cycle, cam_search_data_o=key.
  - EVAL: samples cam_search_valid_i/index_i; hit_v = cam_search_valid_i & valid[cam_search_index_i].
  - WRITE: cam_write_o=1 for exactly one cycle.
  - RESP: waits for rsp_ready_i.
- **Lookup:** EVAL -> RESP. rsp_hit_o=hit_v. rsp_index_o=cam_search_index_i if hit_v, else 0.
- **Insert decision in EVAL (first matching case applies):**
  - (a) hit_v: no write; rsp_hit_o=1, index=match.
  - (b) CAM match on an invalid entry (stale or post-reset garbage): reuse that index. WRITE rewrites the key, valid is set, rsp_hit_o=0.
  - (c) No match and a free entry exists: use the lowest-index invalid entry. WRITE, set valid, rsp_hit_o=0.
  - (d) No match and full: victim = eviction pointer. WRITE, rsp_evict_o=1, pointer increments mod DEPTH (wraps 31->0).
- **Delete:**
  - Clears valid[req_index_i] on the cycle IDLE->RESP; no CAM access.
  - rsp_hit_o = prior valid bit; rsp_index_o = req_index_i.
  - Deleting an already-invalid entry does not change occupancy.
- **Reserved op:** RESP with hit=0, index=0, evict=0; no CAM access and no state change.
- **Invariants:**
  - The CAM never holds two valid entries with equal keys. Because the CAM priority encoder returns the lowest match, stale duplicates are harmless.
  - occupancy_o updates on the same edge the valid bit changes and saturates at DEPTH.
- **Latency, request fire to rsp_valid_o high:**
  - Lookup: 3 cycles.
  - Insert with write: 4 cycles.
  - Insert hit: 3 cycles.
  - Delete or reserved: 1 cycle.

Test Plan:
1. Reset, then insert 0xDEADBEEF -> cam_write_o at index 0; rsp hit=0 idx=0 evict=0; occupancy_o=1. Lookup of the same key -> hit=1 idx=0.
2. Insert 0xDEADBEEF again -> no cam_write_o; rsp hit=1 idx=0; occupancy_o stays 1.
3. Insert keys 0..31 into an empty CAM -> indices 0..31; occupancy_o=32. Insert 0x100 -> write idx 0, evict=1. Insert 0x101 -> idx 1, evict=1 (pointer wrap checked after 32 evictions).
4. Delete idx 5 (valid) -> hit=1, occupancy_o decrements. Lookup of the key at idx 5 -> hit=0. Re-insert the same key -> reuses idx 5 with hit=0.
5. Hold rsp_ready_i=0 for 10 cycles after a lookup -> rsp fields stable and req_ready_o=0 throughout. Release -> idle next cycle.
6. Assert rst_i=0 while in WRITE -> cam_write_o drops immediately; no response; occupancy_o=0; req_ready_o=1 after release.
